// File: rtl/ysyx_22050550_fetch_pkg.sv
// Shared widths, reset PC and state encoding for the fetch sequencer.
// Optional watchdog is enabled by defining YSYX_22050550_FETCH_TIMEOUT_EN.
package ysyx_22050550_fetch_pkg;

   localparam int unsigned PC_BUS   = 64;
   localparam int unsigned INST_BUS = 32;

   localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

   typedef enum logic [2:0] {
      ST_RESET = 3'd0,
      ST_REQ   = 3'd1,
      ST_VALID = 3'd2,
      ST_DROP  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_HALT  = 3'd5
   } fetch_state_e;

endpackage

// File: rtl/ysyx_22050550_fetch_wdog.sv
// Watchdog for an outstanding instruction-memory request. Counts cycles in
// which a request is pending and not acknowledged; fires on reaching LIMIT.
// Only instantiated when YSYX_22050550_FETCH_TIMEOUT_EN is defined.
module ysyx_22050550_fetch_wdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_cnt_en,
   output logic o_fire
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_base;
   logic [CW-1:0] w_next;

   // i_clr marks the first cycle of a new wait, so that cycle counts from zero
   assign w_base = i_clr ? '0 : r_cnt;
   assign w_next = w_base + CW'(1);
   assign o_fire = i_cnt_en && (w_next == CW'(LIMIT));

   // wait-cycle counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_cnt_en) begin
         r_cnt <= w_next;
      end else begin
         r_cnt <= w_base;
      end
   end

endmodule

// File: rtl/ysyx_22050550_fetch_ctrl.sv
// Fetch sequencer in front of IF/ID: owns the fetch PC, issues one memory
// read at a time, hands instructions to IF/ID, applies redirects and halt.
// Define YSYX_22050550_FETCH_TIMEOUT_EN to build the request watchdog.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RESET    | first cycle after reset release, no request yet
// REQ      | request for pc outstanding
// VALID    | instruction buffered, offered to IF/ID
// DROP     | stale request outstanding, its data will be discarded
// DRAIN    | stale request outstanding, halt once it completes
// HALT     | fetch stopped until reset
module ysyx_22050550_fetch_ctrl
   import ysyx_22050550_fetch_pkg::*;
#(
   parameter int unsigned PC_WIDTH       = PC_BUS,
   parameter int unsigned INST_WIDTH     = INST_BUS,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   input  logic                  halt_i,
   output logic                  mem_req,
   output logic [PC_WIDTH-1:0]   mem_addr,
   input  logic                  mem_ack,
   input  logic [INST_WIDTH-1:0] mem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PC_WIDTH-1:0]   out_pc,
   output logic [INST_WIDTH-1:0] out_inst,
   output logic                  halted,
   output logic                  timeout_o
);

   fetch_state_e          r_state;
   logic [PC_WIDTH-1:0]   r_pc;
   logic [PC_WIDTH-1:0]   r_addr;
   logic                  r_mem_req;
   logic                  r_out_valid;
   logic [PC_WIDTH-1:0]   r_out_pc;
   logic [INST_WIDTH-1:0] r_out_inst;
   logic                  r_halted;
   logic                  w_fire;

   // r_addr differs from r_pc only while a stale request is being drained
   assign mem_req   = r_mem_req;
   assign mem_addr  = r_addr;
   assign out_valid = r_out_valid;
   assign out_pc    = r_out_pc;
   assign out_inst  = r_out_inst;
   assign halted    = r_halted;

`ifdef YSYX_22050550_FETCH_TIMEOUT_EN
   logic r_wd_clr;
   logic r_timeout;

   // flag the first cycle of every REQ/DROP/DRAIN visit so the watchdog restarts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wd_clr <= 1'b0;
      end else begin
         unique case (r_state)
            ST_RESET: r_wd_clr <= 1'b1;
            ST_REQ:   r_wd_clr <= !w_fire && (halt_i ? !mem_ack : redirect_valid);
            ST_VALID: r_wd_clr <= !halt_i && (redirect_valid || out_ready);
            ST_DROP:  r_wd_clr <= !w_fire && (halt_i ? !mem_ack : mem_ack);
            default:  r_wd_clr <= 1'b0;
         endcase
      end
   end

   ysyx_22050550_fetch_wdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (r_wd_clr),
      .i_cnt_en (r_mem_req && !mem_ack),
      .o_fire   (w_fire)
   );

   // sticky timeout flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= r_timeout | w_fire;
      end
   end

   assign timeout_o = r_timeout;
`else
   assign w_fire    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // fetch sequencing FSM; halt beats redirect, redirect beats out_ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_RESET;
         r_pc        <= RESET_PC;
         r_addr      <= RESET_PC;
         r_mem_req   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_pc    <= '0;
         r_out_inst  <= '0;
         r_halted    <= 1'b0;
      end else begin
         unique case (r_state)
            ST_RESET: begin
               r_state   <= ST_REQ;
               r_mem_req <= 1'b1;
               r_addr    <= r_pc;
            end
            ST_REQ: begin
               if (w_fire) begin
                  r_state   <= ST_HALT;
                  r_mem_req <= 1'b0;
                  r_halted  <= 1'b1;
               end else if (halt_i) begin
                  if (mem_ack) begin
                     r_state   <= ST_HALT;
                     r_mem_req <= 1'b0;
                     r_halted  <= 1'b1;
                  end else begin
                     r_state <= ST_DRAIN;
                  end
               end else if (redirect_valid) begin
                  r_pc <= redirect_pc;
                  // with ack the old data is simply ignored and the new request starts at once
                  if (mem_ack) begin
                     r_addr <= redirect_pc;
                  end else begin
                     r_state <= ST_DROP;
                  end
               end else if (mem_ack) begin
                  r_state     <= ST_VALID;
                  r_mem_req   <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_out_pc    <= r_pc;
                  r_out_inst  <= mem_rdata;
               end
            end
            ST_VALID: begin
               if (halt_i) begin
                  r_state     <= ST_HALT;
                  r_out_valid <= 1'b0;
                  r_halted    <= 1'b1;
               end else if (redirect_valid) begin
                  r_state     <= ST_REQ;
                  r_out_valid <= 1'b0;
                  r_mem_req   <= 1'b1;
                  r_pc        <= redirect_pc;
                  r_addr      <= redirect_pc;
               end else if (out_ready) begin
                  r_state     <= ST_REQ;
                  r_out_valid <= 1'b0;
                  r_mem_req   <= 1'b1;
                  r_pc        <= r_pc + PC_WIDTH'(4);
                  r_addr      <= r_pc + PC_WIDTH'(4);
               end
            end
            ST_DROP: begin
               if (w_fire) begin
                  r_state   <= ST_HALT;
                  r_mem_req <= 1'b0;
                  r_halted  <= 1'b1;
               end else if (halt_i) begin
                  if (mem_ack) begin
                     r_state   <= ST_HALT;
                     r_mem_req <= 1'b0;
                     r_halted  <= 1'b1;
                  end else begin
                     r_state <= ST_DRAIN;
                  end
               end else begin
                  if (redirect_valid) begin
                     r_pc <= redirect_pc;
                  end
                  if (mem_ack) begin
                     r_state <= ST_REQ;
                     r_addr  <= redirect_valid ? redirect_pc : r_pc;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_fire || mem_ack) begin
                  r_state   <= ST_HALT;
                  r_mem_req <= 1'b0;
                  r_halted  <= 1'b1;
               end
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state     <= ST_HALT;
               r_mem_req   <= 1'b0;
               r_out_valid <= 1'b0;
               r_halted    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050550_fetch_ctrl.sv
// Randomised bench for the fetch sequencer with a transaction-level model.
module tb_ysyx_22050550_fetch_ctrl;

   localparam logic [63:0] RST_PC = 64'h8000_0000;
   localparam int unsigned TB_TO  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt_i;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic        halted;
   logic        timeout_o;

   int n_checks = 0;
   int n_errors = 0;

   // model: either holding one instruction or fetching exp_pc
   bit          m_started;
   bit          m_buf;
   bit          m_stale;
   logic [63:0] m_stale_addr;
   logic [63:0] m_exp_pc;
   int          waited;
   int          hs_cnt;
   logic [63:0] last_hs_pc;
   logic [63:0] acked_q[$];

   ysyx_22050550_fetch_ctrl #(.TIMEOUT_CYCLES(TB_TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_i         (halt_i),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .halted         (halted),
      .timeout_o      (timeout_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [31:0] memfn(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      m_buf     = 1'b0;
      m_stale   = 1'b0;
      m_exp_pc  = RST_PC;
      waited    = 0;
      hs_cnt    = 0;
      acked_q.delete();
   endtask

   // one cycle: check outputs against the model, drive inputs, advance model
   task automatic step(input logic rv, input logic [63:0] rpc, input logic ack, input logic rdy);
      chk("out_valid", out_valid, m_buf);
      chk("mem_req", mem_req, m_started && !m_buf);
      chk("halted", halted, 0);
      if (m_buf) begin
         chk("out_pc", out_pc, m_exp_pc);
         chk("out_inst", out_inst, memfn(m_exp_pc));
      end
      if (m_started && !m_buf) chk("mem_addr", mem_addr, m_stale ? m_stale_addr : m_exp_pc);
      redirect_valid = rv;
      redirect_pc    = rpc;
      mem_ack        = ack;
      out_ready      = rdy;
      halt_i         = 1'b0;
      mem_rdata      = ack ? memfn(mem_addr) : $urandom;
      if (mem_req && ack) acked_q.push_back(mem_addr);
      if (out_valid && rdy) begin
         hs_cnt++;
         last_hs_pc = out_pc;
      end
      waited = (mem_req && !ack) ? waited + 1 : 0;
      if (!m_started) begin
         m_started = 1'b1;
      end else if (m_buf) begin
         if (rv) m_exp_pc = rpc;
         else if (rdy) m_exp_pc = m_exp_pc + 64'd4;
         if (rv || rdy) m_buf = 1'b0;
      end else begin
         if (ack) begin
            if (m_stale) m_stale = 1'b0;
            else if (!rv) m_buf = 1'b1;
         end
         if (rv) begin
            if (!ack && !m_stale) begin
               m_stale      = 1'b1;
               m_stale_addr = m_exp_pc;
            end
            m_exp_pc = rpc;
         end
      end
      tick();
   endtask

   task automatic fast_step(input logic rdy);
      step(1'b0, {$urandom, $urandom}, mem_req && (waited >= 1), rdy);
   endtask

   task automatic run_until_hs(input int target, input string tag);
      int budget = 0;
      while (hs_cnt < target && budget < 200) begin
         fast_step(1'b1);
         budget++;
      end
      chk(tag, 64'(hs_cnt), 64'(target));
   endtask

   task automatic run_until_valid(input string tag);
      int budget = 0;
      while (!out_valid && budget < 50) begin
         fast_step(1'b0);
         budget++;
      end
      chk(tag, out_valid, 1);
   endtask

   task automatic run_until_req(input string tag);
      int budget = 0;
      while (!mem_req && budget < 50) begin
         step(1'b0, {$urandom, $urandom}, 1'b0, 1'b1);
         budget++;
      end
      chk(tag, mem_req, 1);
   endtask

   initial begin
      logic [63:0] held;
      int          hs0;
      int          bad;
      int          cnt;

      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_i = 1'b0;
      mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;
      model_reset();
      #23;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_inst", out_inst, 0);
      chk("rst_halted", halted, 0);
      chk("rst_timeout", timeout_o, 0);
      chk("rst_mem_addr", mem_addr, RST_PC);
      @(negedge clk);
      rst = 1'b1;

      // sequential fetch, ack one cycle after request
      run_until_hs(3, "t1_hs");
      chk("t1_addr0", acked_q[0], 64'h8000_0000);
      chk("t1_addr1", acked_q[1], 64'h8000_0004);
      chk("t1_addr2", acked_q[2], 64'h8000_0008);

      // back-pressure for 5 cycles
      run_until_valid("t2_valid");
      held = out_pc;
      repeat (5) fast_step(1'b0);
      chk("t2_pc_held", out_pc, held);
      chk("t2_req_low", mem_req, 0);
      fast_step(1'b1);
      chk("t2_next_addr", mem_addr, held + 64'd4);

      // redirect with a late ack; stale data must never appear
      step(1'b1, 64'h8000_1000, 1'b0, 1'b1);
      step(1'b0, {$urandom, $urandom}, 1'b0, 1'b1);
      step(1'b0, {$urandom, $urandom}, 1'b0, 1'b1);
      step(1'b0, {$urandom, $urandom}, 1'b1, 1'b1);
      chk("t3_addr", mem_addr, 64'h8000_1000);
      hs0 = hs_cnt;
      run_until_hs(hs0 + 1, "t3_hs");
      chk("t3_out_pc", last_hs_pc, 64'h8000_1000);

      // redirect together with out_ready
      run_until_valid("t4_valid");
      hs0 = hs_cnt;
      step(1'b1, 64'h8000_2000, 1'b0, 1'b1);
      chk("t4_hs_done", 64'(hs_cnt), 64'(hs0 + 1));
      chk("t4_addr", mem_addr, 64'h8000_2000);
      run_until_hs(hs0 + 2, "t4_hs");
      chk("t4_out_pc", last_hs_pc, 64'h8000_2000);

      // PC wrap-around
      run_until_valid("t5_valid");
      step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
      hs0 = hs_cnt;
      run_until_hs(hs0 + 1, "t5_hs0");
      chk("t5_top_pc", last_hs_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      run_until_hs(hs0 + 2, "t5_hs1");
      chk("t5_wrap_pc", last_hs_pc, 64'h0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         logic rv;
         logic ack;
         rv  = ($urandom_range(0, 7) == 0);
         ack = mem_req ? ((waited >= 3) || ($urandom_range(0, 2) == 0))
                       : ($urandom_range(0, 3) == 0);
         step(rv, {$urandom, $urandom}, ack, 1'($urandom_range(0, 1)));
      end
      chk("rand_progress", 64'(hs_cnt > 100), 1);

      // halt during an outstanding request, ack two cycles later
      run_until_req("h_req");
      halt_i = 1'b1; redirect_valid = 1'b0; mem_ack = 1'b0;
      tick();
      chk("h_drain_req", mem_req, 1);
      chk("h_drain_halted", halted, 0);
      tick();
      mem_ack = 1'b1; mem_rdata = $urandom;
      tick();
      mem_ack = 1'b0;
      chk("h_halted", halted, 1);
      chk("h_req_low", mem_req, 0);
      chk("h_valid_low", out_valid, 0);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         redirect_valid = 1'b1;
         redirect_pc    = {$urandom, $urandom};
         mem_ack        = 1'($urandom_range(0, 1));
         halt_i         = 1'($urandom_range(0, 1));
         out_ready      = 1'b1;
         tick();
         if (mem_req || out_valid) bad++;
      end
      chk("h_quiet", 64'(bad), 0);
      chk("h_sticky", halted, 1);

      // asynchronous reset mid-cycle, then restart
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("ar_mem_req", mem_req, 0);
      chk("ar_out_valid", out_valid, 0);
      chk("ar_halted", halted, 0);
      chk("ar_out_pc", out_pc, 0);
      chk("ar_out_inst", out_inst, 0);
      chk("ar_timeout", timeout_o, 0);
      halt_i = 1'b0; redirect_valid = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      fast_step(1'b1);
      chk("ar_restart_req", mem_req, 1);
      chk("ar_restart_addr", mem_addr, RST_PC);
      run_until_hs(2, "ar_hs");
      chk("ar_first_ack", acked_q[0], RST_PC);

`ifdef YSYX_22050550_FETCH_TIMEOUT_EN
      // watchdog: ack never arrives
      @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; mem_ack = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; halt_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (mem_req) cnt++;
      end
      chk("to_cycles", 64'(cnt), 64'(TB_TO));
      chk("to_flag", timeout_o, 1);
      chk("to_halted", halted, 1);
      chk("to_req_low", mem_req, 0);
      @(posedge clk);
      #4 rst = 1'b0;
      #1;
      chk("to_rst_flag", timeout_o, 0);
      chk("to_rst_halted", halted, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("to_restart_req", mem_req, 1);
      chk("to_restart_addr", mem_addr, RST_PC);
`else
      cnt = 0;
      mem_ack = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (timeout_o) cnt++;
      end
      chk("no_timeout", 64'(cnt), 0);
      chk("no_timeout_req", mem_req, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
